spi_fifo_slave: RTL

SPI_FIFO_SLAVE -- requirements
Module: spi_fifo_slave

---
 rtl/spi_fifo_pkg.sv | 38 +++
 rtl/spi_sync_fifo.sv | 56 +++++
 rtl/spi_fifo_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fifo_pkg.sv
// Shared definitions for the FIFO-buffered SPI master block:
// register offsets, STATUS/CTRL bit positions, CTRL layout, engine states.
package spi_fifo_pkg;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_DIV    = 2'd3;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_RX_EMPTY = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_TX_OVF   = 6;
    localparam int ST_RXCNT_LO = 8;

    localparam int CT_CLR      = 31;
    localparam int CT_W        = 7;

    // Bit order matches CTRL[6:0]: idx[6:4] irq_en[3] cpha[2] cpol[1] en[0]
    typedef struct packed {
        logic [2:0] idx;
        logic       irq_en;
        logic       cpha;
        logic       cpol;
        logic       en;
    } ctrl_t;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_SETUP,
        ENG_SHIFT,
        ENG_HOLD
    } eng_state_e;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy count, full and empty flags.
// Ports: clk_i, rst_ni, push_i/wdata_i, pop_i/rdata_o (show-ahead), count_o, full_o, empty_o.
module spi_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, wptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_pop, do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // is accepted when it coincides with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/spi_fifo_slave.sv
// Bus-mapped SPI master with TX/RX FIFOs, 4-register window, level irq.
// Ports: HCLK_i/HRESETn_i, bus (HADDR_bi, HWDATA_bi, HWRITE_i, CS_bi, HRDATA_bo), SPI (sclk_o, mosi_o, miso_i, cs_bo), irq_o.
module spi_fifo_slave #(
    parameter int BASE_ADDR = 0,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter int N_CS      = 4,
    parameter int DIV_RESET = 10
) (
    input  logic              HCLK_i,
    input  logic              HRESETn_i,
    input  logic [31:0]       HADDR_bi,
    input  logic [31:0]       HWDATA_bi,
    input  logic              HWRITE_i,
    input  logic [2:0]        CS_bi,
    output logic [31:0]       HRDATA_bo,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [N_CS-1:0]   cs_bo,
    output logic              irq_o
);

    import spi_fifo_pkg::*;

    localparam int         CW    = $clog2(DEPTH) + 1;
    localparam logic [6:0] EDGES = 7'(2 * DATA_W);

    // Bus decode
    logic [31:0] offs;
    logic        hit, wr, rd_any;
    logic [1:0]  reg_sel;
    logic        unused_hw;

    assign offs      = HADDR_bi - 32'(BASE_ADDR);
    assign hit       = (CS_bi != 3'd0) && (offs < 32'd16);
    assign reg_sel   = HADDR_bi[3:2];
    assign wr        = hit & HWRITE_i;
    assign rd_any    = (CS_bi != 3'd0) & ~HWRITE_i;
    assign unused_hw = ^HWDATA_bi;

    // Register state
    ctrl_t       ctrl_q;
    logic [15:0] div_q;
    logic        tx_ovf_q, tx_ovf_d;
    logic        rx_ovr_q, rx_ovr_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        clr;

    // FIFOs
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] tx_rdata, rx_rdata;
    logic [CW-1:0]     tx_cnt, rx_cnt;
    logic              unused_txcnt;

    assign unused_txcnt = ^tx_cnt;

    // Engine state
    eng_state_e        state_q;
    logic [15:0]       div_e_q, cnt_q, div_eff;
    logic [6:0]        edge_q;
    logic              cpha_q, sclk_q, mosi_q;
    logic [DATA_W-1:0] txsh_q, rxsh_q;
    logic [N_CS-1:0]   cs_q, cs_sel;
    logic              edge_fire, lead, busy;

    assign tx_push = wr & (reg_sel == OFF_DATA);
    assign rx_pop  = hit & ~HWRITE_i & (reg_sel == OFF_DATA);
    assign tx_pop  = (state_q == ENG_IDLE) & ctrl_q.en & ~tx_empty;
    assign rx_push = (state_q == ENG_SHIFT) & (cnt_q == 16'd0)
                   & (edge_q == EDGES);

    spi_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk_i   (HCLK_i),
        .rst_ni  (HRESETn_i),
        .push_i  (tx_push),
        .wdata_i (HWDATA_bi[DATA_W-1:0]),
        .pop_i   (tx_pop),
        .rdata_o (tx_rdata),
        .count_o (tx_cnt),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    spi_sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk_i   (HCLK_i),
        .rst_ni  (HRESETn_i),
        .push_i  (rx_push),
        .wdata_i (rxsh_q),
        .pop_i   (rx_pop),
        .rdata_o (rx_rdata),
        .count_o (rx_cnt),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign busy    = (state_q != ENG_IDLE);
    assign clr     = wr & (reg_sel == OFF_CTRL) & HWDATA_bi[CT_CLR];
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

    // Sticky flags: a new event in the clearing cycle still latches.
    assign tx_ovf_d = (tx_ovf_q & ~clr) | (tx_push & tx_full & ~tx_pop);
    assign rx_ovr_d = (rx_ovr_q & ~clr) | (rx_push & rx_full & ~rx_pop);
    assign irq_d    = ctrl_q.irq_en & (~rx_empty | rx_ovr_q);

    always_comb begin
        rdata_d = 32'd0;
        if (hit) begin
            case (reg_sel)
                OFF_DATA: begin
                    if (!rx_empty) rdata_d = 32'(rx_rdata);
                end
                OFF_STATUS: begin
                    rdata_d[ST_BUSY]     = busy;
                    rdata_d[ST_TX_FULL]  = tx_full;
                    rdata_d[ST_TX_EMPTY] = tx_empty;
                    rdata_d[ST_RX_FULL]  = rx_full;
                    rdata_d[ST_RX_EMPTY] = rx_empty;
                    rdata_d[ST_RX_OVR]   = rx_ovr_q;
                    rdata_d[ST_TX_OVF]   = tx_ovf_q;
                    rdata_d[ST_RXCNT_LO +: 8] = 8'(rx_cnt);
                end
                OFF_CTRL: rdata_d = {25'd0, ctrl_q};
                default:  rdata_d = {16'd0, div_q};
            endcase
        end
    end

    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            ctrl_q   <= '0;
            div_q    <= 16'(DIV_RESET);
            tx_ovf_q <= 1'b0;
            rx_ovr_q <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            if (wr && reg_sel == OFF_CTRL) ctrl_q <= ctrl_t'(HWDATA_bi[CT_W-1:0]);
            if (wr && reg_sel == OFF_DIV)  div_q  <= HWDATA_bi[15:0];
            tx_ovf_q <= tx_ovf_d;
            rx_ovr_q <= rx_ovr_d;
            irq_q    <= irq_d;
            if (rd_any) rdata_q <= rdata_d;
        end
    end

    always_comb begin
        cs_sel = '1;
        for (int i = 0; i < N_CS; i++) begin
            if (ctrl_q.idx == 3'(i)) cs_sel[i] = 1'b0;
        end
    end

    // Edge 1 fires as SETUP expires; odd edge numbers are leading edges.
    assign edge_fire = (cnt_q == 16'd0)
                     & ((state_q == ENG_SETUP)
                     | ((state_q == ENG_SHIFT) & (edge_q != EDGES)));
    assign lead      = (state_q == ENG_SETUP) | ~edge_q[0];

    always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
        if (!HRESETn_i) begin
            state_q <= ENG_IDLE;
            div_e_q <= 16'd1;
            cnt_q   <= 16'd0;
            edge_q  <= 7'd0;
            cpha_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            txsh_q  <= '0;
            rxsh_q  <= '0;
            cs_q    <= '1;
        end else begin
            unique case (state_q)
                ENG_IDLE: begin
                    cs_q   <= '1;
                    sclk_q <= ctrl_q.cpol;
                    if (tx_pop) begin
                        state_q <= ENG_SETUP;
                        div_e_q <= div_eff;
                        cnt_q   <= div_eff - 16'd1;
                        cpha_q  <= ctrl_q.cpha;
                        cs_q    <= cs_sel;
                        if (!ctrl_q.cpha) begin
                            mosi_q <= tx_rdata[DATA_W-1];
                            txsh_q <= {tx_rdata[DATA_W-2:0], 1'b0};
                        end else begin
                            txsh_q <= tx_rdata;
                        end
                    end
                end
                ENG_SETUP: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ENG_SHIFT;
                        cnt_q   <= div_e_q - 16'd1;
                        edge_q  <= 7'd1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ENG_SHIFT: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= div_e_q - 16'd1;
                        if (edge_q == EDGES) state_q <= ENG_HOLD;
                        else                 edge_q  <= edge_q + 7'd1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ENG_HOLD: begin
                    if (cnt_q == 16'd0) begin
                        state_q <= ENG_IDLE;
                        cs_q    <= '1;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: state_q <= ENG_IDLE;
            endcase
            if (edge_fire) begin
                sclk_q <= ~sclk_q;
                if (lead == cpha_q) begin
                    mosi_q <= txsh_q[DATA_W-1];
                    txsh_q <= {txsh_q[DATA_W-2:0], 1'b0};
                end else begin
                    rxsh_q <= {rxsh_q[DATA_W-2:0], miso_i};
                end
            end
        end
    end

    assign HRDATA_bo = rdata_q;
    assign sclk_o    = sclk_q;
    assign mosi_o    = mosi_q;
    assign cs_bo     = cs_q;
    assign irq_o     = irq_q;

endmodule
